// File: rtl/bus_pkg.sv
// Shared bus definitions: source index map, default sizes and conflict counter helpers.
package bus_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int BUS_NSRC       = 24;
  localparam int CONFLICT_CNT_W = 8;

  // Datapath source indices as wired on the CPU bus.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

  // Increment that sticks at the counter's maximum instead of wrapping.
  function automatic logic [CONFLICT_CNT_W-1:0] cnt_sat_inc(
    input logic [CONFLICT_CNT_W-1:0] v
  );
    return (v == CONFLICT_CNT_MAX) ? v : v + CONFLICT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/prio_enc_onehot.sv
// Priority encoder for out-enables: lowest set index wins, plus any/multi flags.
module prio_enc_onehot #(
  parameter int  N     = 24,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps always_comb free of latches.
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/bus_mux_hold.sv
// N-source bus multiplexer with bus-keeper hold, optional output register and conflict monitor.
module bus_mux_hold
  import bus_pkg::*;
#(
  parameter int  WIDTH = BUS_WIDTH,
  parameter int  N_SRC = BUS_NSRC,
  parameter int  PIPE  = 1,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [N_SRC*WIDTH-1:0]    src_data,
  input  logic [N_SRC-1:0]          src_en,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_sel,
  output logic                      conflict,
  output logic                      conflict_sticky,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

  logic [SEL_W-1:0]          winner;
  logic                      any_en;
  logic                      multi_en;
  logic [WIDTH-1:0]          win_data;
  logic [WIDTH-1:0]          hold_q, hold_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      conflict_q;
  logic                      sticky_q, sticky_d;
  logic [CONFLICT_CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  prio_enc_onehot #(.N(N_SRC)) u_enc (
    .req_i   (src_en),
    .idx_o   (winner),
    .any_o   (any_en),
    .multi_o (multi_en)
  );

  // Select the winning source's word out of the flattened data bus.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (winner == SEL_W'(i)) win_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  // The keeper reloads only while something drives, so the bus never floats.
  assign hold_d = any_en ? win_data : hold_q;
  assign sel_d  = any_en ? winner   : sel_q;

  // Bus-keeper value and last winning index.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      hold_q <= '0;
      sel_q  <= '0;
    end else begin
      hold_q <= hold_d;
      sel_q  <= sel_d;
    end
  end

  // Conflict next state: a conflict on the clearing edge counts as a fresh first event.
  always_comb begin
    cnt_base = err_clr ? '0 : cnt_q;
    sticky_d = err_clr ? 1'b0 : sticky_q;
    cnt_d    = cnt_base;
    if (multi_en) begin
      sticky_d = 1'b1;
      cnt_d    = cnt_sat_inc(cnt_base);
    end
  end

  // Conflict pulse, sticky flag and saturating counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= multi_en;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;

  if (PIPE != 0) begin : g_pipe
    logic valid_q;

    // Registered valid flag for the output stage.
    always_ff @(posedge clock or negedge clear) begin
      if (!clear) valid_q <= 1'b0;
      else        valid_q <= any_en;
    end

    // The output register would load exactly what hold_q loads on every edge, so it is hold_q.
    assign bus_out   = hold_q;
    assign bus_valid = valid_q;
    assign bus_sel   = sel_q;
  end else begin : g_comb
    assign bus_out   = hold_d;
    assign bus_valid = any_en;
    assign bus_sel   = sel_d;
  end

endmodule

// File: tb/tb_bus_mux_hold.sv
// Self-checking bench: both PIPE settings side by side against a cycle-level behavioural model.
module tb_bus_mux_hold;
  import bus_pkg::*;

  localparam int W  = BUS_WIDTH;
  localparam int N  = BUS_NSRC;
  localparam int SW = $clog2(N);

  logic             clock   = 1'b0;
  logic             clear   = 1'b1;
  logic             err_clr = 1'b0;
  logic [N*W-1:0]   src_data = '0;
  logic [N-1:0]     src_en   = '0;

  logic [W-1:0]     d1_out,    d0_out;
  logic             d1_valid,  d0_valid;
  logic [SW-1:0]    d1_sel,    d0_sel;
  logic             d1_conf,   d0_conf;
  logic             d1_sticky, d0_sticky;
  logic [7:0]       d1_cnt,    d0_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bus_mux_hold #(.WIDTH(W), .N_SRC(N), .PIPE(1)) dut1 (
    .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en), .err_clr(err_clr),
    .bus_out(d1_out), .bus_valid(d1_valid), .bus_sel(d1_sel), .conflict(d1_conf),
    .conflict_sticky(d1_sticky), .conflict_cnt(d1_cnt)
  );

  bus_mux_hold #(.WIDTH(W), .N_SRC(N), .PIPE(0)) dut0 (
    .clock(clock), .clear(clear), .src_data(src_data), .src_en(src_en), .err_clr(err_clr),
    .bus_out(d0_out), .bus_valid(d0_valid), .bus_sel(d0_sel), .conflict(d0_conf),
    .conflict_sticky(d0_sticky), .conflict_cnt(d0_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) if (en[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] word(input int i);
    return src_data[i*W +: W];
  endfunction

  task automatic set_word(input int i, input logic [W-1:0] v);
    src_data[i*W +: W] = v;
  endtask

  // Behavioural model state: what the bus holds, who drove it last, and the conflict record.
  logic [W-1:0] m_hold, m_out1;
  int           m_sel, m_sel1, m_cnt;
  bit           m_valid1, m_conf, m_sticky;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_hold <= '0; m_out1 <= '0; m_sel <= 0; m_sel1 <= 0;
      m_valid1 <= 1'b0; m_conf <= 1'b0; m_sticky <= 1'b0; m_cnt <= 0;
    end else begin : model_step
      int w, n, base;
      w = lowest(src_en);
      n = $countones(src_en);
      base = err_clr ? 0 : m_cnt;
      m_out1   <= (w >= 0) ? word(w) : m_hold;
      m_valid1 <= (w >= 0);
      if (w >= 0) begin
        m_hold <= word(w);
        m_sel  <= w;
        m_sel1 <= w;
      end
      m_conf   <= (n > 1);
      m_sticky <= (n > 1) ? 1'b1 : (err_clr ? 1'b0 : m_sticky);
      m_cnt    <= (n > 1) ? ((base >= 255) ? 255 : base + 1) : base;
    end
  end

  // Every cycle, away from the active edge, both DUTs against the model.
  always @(negedge clock) begin
    if (chk_en) begin : cmp
      int w;
      logic [W-1:0] e_out0;
      int e_sel0;
      w = lowest(src_en);
      e_out0 = (w >= 0) ? word(w) : m_hold;
      e_sel0 = (w >= 0) ? w : m_sel;
      check("p1_bus_out",  d1_out, m_out1);
      check("p1_valid",    32'(d1_valid),  32'(m_valid1));
      check("p1_sel",      32'(d1_sel),    32'(m_sel1));
      check("p1_conflict", 32'(d1_conf),   32'(m_conf));
      check("p1_sticky",   32'(d1_sticky), 32'(m_sticky));
      check("p1_cnt",      32'(d1_cnt),    32'(m_cnt));
      check("p0_bus_out",  d0_out, e_out0);
      check("p0_valid",    32'(d0_valid),  32'(w >= 0));
      check("p0_sel",      32'(d0_sel),    32'(e_sel0));
      check("p0_conflict", 32'(d0_conf),   32'(m_conf));
      check("p0_sticky",   32'(d0_sticky), 32'(m_sticky));
      check("p0_cnt",      32'(d0_cnt),    32'(m_cnt));
    end
  end

  // Apply one cycle of enables just after an edge and step to just after the next edge.
  task automatic cyc(input logic [N-1:0] en, input logic ec);
    src_en  = en;
    err_clr = ec;
    @(posedge clock);
    #1;
  endtask

  localparam logic [N-1:0] EN_R3R7 = (N'(1) << SRC_R3) | (N'(1) << SRC_R7);

  initial begin
    for (int i = 0; i < N; i++) set_word(i, $urandom);

    // Reset state
    #2 clear = 1'b0;
    #1;
    check("rst_p1_out",    d1_out, '0);
    check("rst_p1_valid",  32'(d1_valid), 0);
    check("rst_p1_sel",    32'(d1_sel), 0);
    check("rst_p1_cnt",    32'(d1_cnt), 0);
    check("rst_p0_out",    d0_out, '0);
    check("rst_p0_sticky", 32'(d0_sticky), 0);
    @(posedge clock);
    #1 clear = 1'b1;
    chk_en = 1'b1;

    // Single drive from PC
    set_word(SRC_PC, 32'h0000_0040);
    cyc(N'(1) << SRC_PC, 1'b0);
    check("pc_out",   d1_out, 32'h40);
    check("pc_valid", 32'(d1_valid), 1);
    check("pc_sel",   32'(d1_sel), 20);
    check("pc_conf",  32'(d1_conf), 0);

    // Drive MDR once, then idle: keeper holds it even as MDR's data moves on
    set_word(SRC_MDR, 32'hDEAD_BEEF);
    cyc(N'(1) << SRC_MDR, 1'b0);
    for (int k = 0; k < 5; k++) begin
      set_word(SRC_MDR, $urandom);
      cyc('0, 1'b0);
      check("hold_p1_out",   d1_out, 32'hDEAD_BEEF);
      check("hold_p1_valid", 32'(d1_valid), 0);
      check("hold_p1_sel",   32'(d1_sel), 21);
      check("hold_p0_out",   d0_out, 32'hDEAD_BEEF);
      check("hold_p0_sel",   32'(d0_sel), 21);
    end

    // Two-source conflict: R3 wins
    set_word(SRC_R3, 32'h11);
    set_word(SRC_R7, 32'h77);
    cyc(EN_R3R7, 1'b0);
    check("conf_out",    d1_out, 32'h11);
    check("conf_sel",    32'(d1_sel), 3);
    check("conf_pulse",  32'(d1_conf), 1);
    check("conf_sticky", 32'(d1_sticky), 1);
    check("conf_cnt",    32'(d1_cnt), 1);
    cyc('0, 1'b0);
    check("conf_pulse_end", 32'(d1_conf), 0);
    check("conf_sticky_kept", 32'(d1_sticky), 1);

    // Saturation, clear, and clear coinciding with a new conflict
    for (int k = 0; k < 300; k++) cyc(EN_R3R7, 1'b0);
    check("sat_cnt", 32'(d1_cnt), 255);
    cyc('0, 1'b1);
    check("clr_cnt",    32'(d1_cnt), 0);
    check("clr_sticky", 32'(d1_sticky), 0);
    cyc(EN_R3R7, 1'b1);
    check("clr_conf_cnt",    32'(d1_cnt), 1);
    check("clr_conf_sticky", 32'(d1_sticky), 1);
    cyc('0, 1'b0);

    // Combinational path switching back to back
    set_word(SRC_R1, 32'hA);
    set_word(SRC_R2, 32'hB);
    src_en = N'(1) << SRC_R1; #1;
    check("sw0_out_a", d0_out, 32'hA);
    check("sw0_sel_a", 32'(d0_sel), 1);
    @(posedge clock); #1;
    check("sw1_out_a", d1_out, 32'hA);
    src_en = N'(1) << SRC_R2; #1;
    check("sw0_out_b", d0_out, 32'hB);
    @(posedge clock); #1;
    check("sw1_out_b", d1_out, 32'hB);
    src_en = N'(1) << SRC_R1; #1;
    check("sw0_out_a2", d0_out, 32'hA);
    @(posedge clock); #1;
    check("sw1_out_a2", d1_out, 32'hA);

    // Randomized traffic: idle, one-hot, pairs and arbitrary masks
    for (int k = 0; k < 2000; k++) begin : rnd
      logic [N-1:0] en;
      int a, b;
      for (int j = 0; j < 4; j++) set_word($urandom_range(0, N - 1), $urandom);
      a = $urandom_range(0, N - 1);
      b = (a + $urandom_range(1, N - 1)) % N;
      case ($urandom_range(0, 3))
        0:       en = '0;
        1:       en = N'(1) << a;
        2:       en = (N'(1) << a) | (N'(1) << b);
        default: en = N'($urandom);
      endcase
      cyc(en, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset while a source is driving
    set_word(5, 32'h5555_5555);
    cyc(EN_R3R7, 1'b0);
    cyc(N'(1) << 5, 1'b0);
    #3 clear = 1'b0;
    #1;
    check("arst_p1_out",    d1_out, '0);
    check("arst_p1_valid",  32'(d1_valid), 0);
    check("arst_p1_sel",    32'(d1_sel), 0);
    check("arst_p1_conf",   32'(d1_conf), 0);
    check("arst_p1_sticky", 32'(d1_sticky), 0);
    check("arst_p1_cnt",    32'(d1_cnt), 0);
    src_en = '0;
    #1;
    check("arst_p0_out",   d0_out, '0);
    check("arst_p0_valid", 32'(d0_valid), 0);
    @(posedge clock);
    #1 clear = 1'b1;
    cyc('0, 1'b0);
    check("post_rst_p1_out",   d1_out, '0);
    check("post_rst_p1_valid", 32'(d1_valid), 0);
    check("post_rst_p0_out",   d0_out, '0);
    check("post_rst_p0_valid", 32'(d0_valid), 0);
    cyc('0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mux_hold.md
# bus_mux_hold

Parametrised N-source datapath bus multiplexer with an integrated one-hot-to-index priority encoder, bus-keeper hold register, optional output pipeline stage and multi-drive conflict monitoring. It replaces the fixed 24-source, externally encoded bus mux in the CPU datapath. Register, HI/LO, Z, PC, MDR, InPort and C out-enables connect directly to it, and its output drives every bus-loaded register.

## Interface
Parameters:
- WIDTH, 32, bus and source data width in bits
- N_SRC, 24, number of bus sources (2..32)
- PIPE, 1, 0 = combinational data path, 1 = registered output stage
- SEL_W, $clog2(N_SRC), width of the selected-index output (derived, not overridden)

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  asynchronous, active-low reset
- src_data  in  N_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- src_en  in  N_SRC  per-source out-enable, intended one-hot
- err_clr  in  1  synchronous clear of conflict_sticky and conflict_cnt
- bus_out  out  WIDTH  bus value
- bus_valid  out  1  bus_out reflects a source driven this cycle (PIPE=0) or last cycle (PIPE=1)
- bus_sel  out  SEL_W  index of the source currently reflected on bus_out
- conflict  out  1  one-cycle pulse: more than one src_en was high in the previous cycle
- conflict_sticky  out  1  set on any conflict; cleared only by err_clr or reset
- conflict_cnt  out  8  saturating count of conflict cycles

## Operation
- Encoder: winner = lowest index i with src_en[i]=1; any = OR of src_en.
- Hold register hold_q updates to src_data[winner] on every edge with any=1. It retains its value when any=0, so the bus never floats or goes X.
- PIPE=1:
  - Each edge: bus_out <= (any ? src_data[winner] : hold_q); bus_valid <= any; bus_sel <= (any ? winner : bus_sel).
- PIPE=0:
  - bus_out = any ? src_data[winner] : hold_q, combinational.
  - bus_valid = any; bus_sel = any ? winner : sel_q, where sel_q is the registered last winner.
- Conflict: popcount(src_en) > 1 is sampled each edge.
  - conflict <= multi.
  - If multi: conflict_sticky <= 1 and conflict_cnt <= min(cnt+1, 255).
  - The lowest-index source still wins the bus. No data corruption by design.
- err_clr: clears sticky and count on the edge. If err_clr and multi fall on the same edge, the new event wins: cnt=1, sticky=1.
- src_en bits at or above N_SRC do not exist. N_SRC not a power of two leaves the upper bus_sel codes unused.

## Timing
- Reset (clear=0, asynchronous): bus_out=0, hold_q=0, bus_valid=0, bus_sel=0, sel_q=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
- Reset mid-transfer: in-flight pipeline data is discarded. The first post-reset edge behaves as a fresh cycle.
- Latency:
  - PIPE=1: src_data/src_en to bus_out, bus_valid and bus_sel is 1 cycle.
  - PIPE=0: 0 cycles for those outputs; hold_q and sel_q update at the edge.
- conflict, sticky and cnt are always registered, with 1-cycle latency in both modes.
- Source switch on consecutive cycles: bus_out follows with no bubble. Each cycle reflects that cycle's winner after the mode latency.
- Idle after drive: bus_out keeps the last driven value indefinitely with bus_valid=0.

## Structure
- Shared package bus_pkg:
  - source index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23
  - BUS_WIDTH=32 and BUS_NSRC=24 defaults
  - CONFLICT_CNT_W=8
- One sub-module: prio_enc_onehot. It is parametrised on N and produces index, any and multi (popcount>1) from src_en.
- Remainder is the data select, hold/sel registers and conflict logic. Target size is 150–250 lines.

## Test plan
- Reset then single drive, PIPE=1: src_en=1<<SRC_PC with PC data 0x0000_0040 -> one cycle later bus_out=0x40, bus_valid=1, bus_sel=20, conflict=0.
- Hold: drive MDR=0xDEAD_BEEF for one cycle, then src_en=0 for 5 cycles -> bus_out stays 0xDEADBEEF, bus_valid=0, bus_sel=21 throughout.
- Conflict: src_en has R3 and R7 high, R3=0x11 and R7=0x77 -> bus_out=0x11, bus_sel=3; conflict pulses for 1 cycle; sticky=1; cnt=1.
- Saturation and clear:
  - 300 consecutive conflict cycles -> cnt=255.
  - err_clr alone -> cnt=0, sticky=0.
  - err_clr together with a conflict -> cnt=1, sticky=1.
- PIPE=0, back-to-back switching: R1=0xA, R2=0xB, R1 on successive cycles -> bus_out changes in the same cycle (0xA, 0xB, 0xA) with no bubble.
- Asynchronous reset mid-stream: assert clear between edges during active drive -> all outputs 0 immediately. After release with src_en=0, bus_out=0 and bus_valid=0.
